// File: rtl/alu_pkg.sv
// Shared widths, ALU function codes and the issue-beat record carried by alu_issue.
package alu_pkg;

  localparam int ALU_XLEN  = 32;
  localparam int ALU_FN_W  = 4;
  localparam int ALU_REG_W = 5;

  localparam logic [ALU_FN_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_FN_W-1:0] ALU_SUB  = 4'd8;
  localparam logic [ALU_FN_W-1:0] ALU_SLL  = 4'd1;
  localparam logic [ALU_FN_W-1:0] ALU_SRL  = 4'd5;
  localparam logic [ALU_FN_W-1:0] ALU_SRA  = 4'd13;
  localparam logic [ALU_FN_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_FN_W-1:0] ALU_OR   = 4'd6;
  localparam logic [ALU_FN_W-1:0] ALU_AND  = 4'd7;
  localparam logic [ALU_FN_W-1:0] ALU_SLT  = 4'd2;
  localparam logic [ALU_FN_W-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALU_FN_W-1:0] ALU_BGE  = 4'd9;
  localparam logic [ALU_FN_W-1:0] ALU_BGEU = 4'd10;

  typedef struct packed {
    logic [ALU_FN_W-1:0]  alu_fn;
    logic [ALU_XLEN-1:0]  operand_a;
    logic [ALU_XLEN-1:0]  operand_b;
    logic                 bneq;
    logic                 btype;
    logic [ALU_REG_W-1:0] rd;
    logic                 we;
    logic [ALU_XLEN-1:0]  pc;
  } issue_beat_t;

endpackage

// File: rtl/alu_fwd_mux.sv
// Forwarding select for one source register: EX result, then WB result, then register file.
module alu_fwd_mux #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             ex_we,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  value
);

  logic rs_nonzero;
  assign rs_nonzero = |rs;

  always_comb begin
    value = rf_data;
    if (ex_we && rs_nonzero && (ex_rd == rs)) begin
      value = ex_data;
    end else if (wb_we && rs_nonzero && (wb_rd == rs)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-issue stage: operand forwarding/select into a main register plus one-entry skid buffer.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int FN_W  = ALU_FN_W,
  parameter int REG_W = ALU_REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [FN_W-1:0]  dec_alu_fn,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic [XLEN-1:0]  dec_rs1_data,
  input  logic [XLEN-1:0]  dec_rs2_data,
  input  logic [XLEN-1:0]  dec_imm,
  input  logic [XLEN-1:0]  dec_pc,
  input  logic             dec_a_pc,
  input  logic             dec_b_imm,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_we,
  input  logic             dec_bneq,
  input  logic             dec_btype,
  input  logic             fwd_ex_we,
  input  logic [REG_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]  fwd_ex_data,
  input  logic             fwd_wb_we,
  input  logic [REG_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [FN_W-1:0]  ex_alu_fn,
  output logic [XLEN-1:0]  ex_operandA,
  output logic [XLEN-1:0]  ex_operandB,
  output logic             ex_bneq,
  output logic             ex_btype,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_we,
  output logic [XLEN-1:0]  ex_pc
);

  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;

  alu_fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs1 (
    .rs      (dec_rs1),
    .rf_data (dec_rs1_data),
    .ex_we   (fwd_ex_we),
    .ex_rd   (fwd_ex_rd),
    .ex_data (fwd_ex_data),
    .wb_we   (fwd_wb_we),
    .wb_rd   (fwd_wb_rd),
    .wb_data (fwd_wb_data),
    .value   (rs1_value)
  );

  alu_fwd_mux #(.XLEN(XLEN), .REG_W(REG_W)) u_fwd_rs2 (
    .rs      (dec_rs2),
    .rf_data (dec_rs2_data),
    .ex_we   (fwd_ex_we),
    .ex_rd   (fwd_ex_rd),
    .ex_data (fwd_ex_data),
    .wb_we   (fwd_wb_we),
    .wb_rd   (fwd_wb_rd),
    .wb_data (fwd_wb_data),
    .value   (rs2_value)
  );

  issue_beat_t in_beat;
  issue_beat_t m_beat, m_beat_nxt;
  issue_beat_t s_beat, s_beat_nxt;
  logic        m_valid, m_valid_nxt;
  logic        s_valid, s_valid_nxt;
  logic        accept;
  logic        drain;
  logic        m_free;

  always_comb begin
    in_beat           = '0;
    in_beat.alu_fn    = dec_alu_fn;
    in_beat.operand_a = dec_a_pc  ? dec_pc  : rs1_value;
    in_beat.operand_b = dec_b_imm ? dec_imm : rs2_value;
    in_beat.bneq      = dec_bneq;
    in_beat.btype     = dec_btype;
    in_beat.rd        = dec_rd;
    in_beat.we        = dec_we;
    in_beat.pc        = dec_pc;
  end

  assign accept = dec_valid & dec_ready;
  assign drain  = m_valid & ex_ready;
  assign m_free = ~m_valid | drain;

  // M takes the oldest held beat first (S), otherwise the incoming one; S only fills behind a stalled M.
  always_comb begin
    m_beat_nxt  = m_beat;
    s_beat_nxt  = s_beat;
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    if (m_free) begin
      if (s_valid) begin
        m_beat_nxt  = s_beat;
        m_valid_nxt = 1'b1;
        s_valid_nxt = accept;
        if (accept) s_beat_nxt = in_beat;
      end else begin
        m_valid_nxt = accept;
        if (accept) m_beat_nxt = in_beat;
      end
    end else if (accept) begin
      s_beat_nxt  = in_beat;
      s_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      dec_ready <= 1'b1;
      m_beat    <= '0;
      s_beat    <= '0;
    end else if (flush) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      dec_ready <= 1'b1;
    end else begin
      m_valid   <= m_valid_nxt;
      s_valid   <= s_valid_nxt;
      dec_ready <= ~s_valid_nxt;
      m_beat    <= m_beat_nxt;
      s_beat    <= s_beat_nxt;
    end
  end

  assign ex_valid    = m_valid;
  assign ex_alu_fn   = m_beat.alu_fn;
  assign ex_operandA = m_beat.operand_a;
  assign ex_operandB = m_beat.operand_b;
  assign ex_bneq     = m_beat.bneq;
  assign ex_btype    = m_beat.btype;
  assign ex_rd       = m_beat.rd;
  assign ex_we       = m_beat.we;
  assign ex_pc       = m_beat.pc;

endmodule
